// File: rtl/core_modport.sv
// ============================================================================
// core_modport : single-outstanding core port to OpenPiton L1.5 transducer
// Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module core_modport #(
  parameter logic [4:0] LOAD_RQ  = 5'b00000,
  parameter logic [4:0] STORE_RQ = 5'b00001,
  parameter logic [3:0] LOAD_RET = 4'h0,
  parameter logic [3:0] ST_ACK   = 4'h4,
  parameter logic [3:0] INT_RET  = 4'h7
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        core_req_val,
  output logic        core_req_rdy,
  input  logic        core_req_we,
  input  logic [1:0]  core_req_size,
  input  logic [31:0] core_req_addr,
  input  logic [31:0] core_req_wdata,
  output logic        core_resp_val,
  output logic [31:0] core_resp_rdata,
  output logic        core_irq,
  output logic [4:0]  transducer_l15_rqtype,
  output logic [2:0]  transducer_l15_size,
  output logic [31:0] transducer_l15_address,
  output logic [63:0] transducer_l15_data,
  output logic        transducer_l15_val,
  input  logic        l15_transducer_ack,
  input  logic        l15_transducer_header_ack,
  input  logic        l15_transducer_val,
  input  logic [63:0] l15_transducer_data_0,
  input  logic [63:0] l15_transducer_data_1,
  input  logic [31:0] l15_transducer_returntype,
  output logic        transducer_l15_req_ack,
  input  logic        external_interrupt
);

  typedef enum logic [1:0] {
    S_INIT = 2'd0,
    S_IDLE = 2'd1,
    S_REQ  = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t      state_q;
  logic        rdy_q;
  logic        resp_val_q;
  logic [31:0] rdata_q;
  logic        irq_q;
  logic        l15_val_q;
  logic [4:0]  rqtype_q;
  logic [2:0]  size_q;
  logic [31:0] addr_q;
  logic [63:0] data_q;
  logic [1:0]  csize_q;

  logic [2:0]  size_enc_d;
  logic [63:0] wdata_rep_d;
  logic [63:0] data_shift_d;
  logic [31:0] load_data_d;
  logic [3:0]  rtype_d;
  logic        unused_inputs;

  assign rtype_d       = l15_transducer_returntype[3:0];
  assign unused_inputs = ^{l15_transducer_header_ack, l15_transducer_data_1,
                           l15_transducer_returntype[31:4]};

  always_comb begin
    size_enc_d  = 3'b011;
    wdata_rep_d = {2{core_req_wdata}};
    case (core_req_size)
      2'd0: begin
        size_enc_d  = 3'b001;
        wdata_rep_d = {8{core_req_wdata[7:0]}};
      end
      2'd1: begin
        size_enc_d  = 3'b010;
        wdata_rep_d = {4{core_req_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Big-endian lanes: shifting the offset byte to the top makes every size an MSB slice.
  assign data_shift_d = l15_transducer_data_0 << {addr_q[2:0], 3'b000};

  always_comb begin
    case (csize_q)
      2'd0:    load_data_d = {24'd0, data_shift_d[63:56]};
      2'd1:    load_data_d = {16'd0, data_shift_d[63:48]};
      default: load_data_d = data_shift_d[63:32];
    endcase
  end

  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) begin
      state_q    <= S_INIT;
      rdy_q      <= 1'b0;
      resp_val_q <= 1'b0;
      rdata_q    <= 32'd0;
      irq_q      <= 1'b0;
      l15_val_q  <= 1'b0;
      rqtype_q   <= 5'd0;
      size_q     <= 3'd0;
      addr_q     <= 32'd0;
      data_q     <= 64'd0;
      csize_q    <= 2'd0;
    end else begin
      irq_q      <= external_interrupt;
      resp_val_q <= 1'b0;
      case (state_q)
        S_INIT: begin
          if (l15_transducer_val && rtype_d == INT_RET) begin
            state_q <= S_IDLE;
            rdy_q   <= 1'b1;
          end
        end
        S_IDLE: begin
          if (core_req_val) begin
            state_q   <= S_REQ;
            rdy_q     <= 1'b0;
            l15_val_q <= 1'b1;
            rqtype_q  <= core_req_we ? STORE_RQ : LOAD_RQ;
            size_q    <= size_enc_d;
            addr_q    <= core_req_addr;
            data_q    <= wdata_rep_d;
            csize_q   <= core_req_size;
          end
        end
        S_REQ: begin
          if (l15_transducer_ack) begin
            state_q   <= S_RESP;
            l15_val_q <= 1'b0;
          end
        end
        S_RESP: begin
          if (l15_transducer_val) begin
            if (rtype_d == LOAD_RET) begin
              state_q    <= S_IDLE;
              rdy_q      <= 1'b1;
              resp_val_q <= 1'b1;
              rdata_q    <= load_data_d;
            end else if (rtype_d == ST_ACK) begin
              state_q    <= S_IDLE;
              rdy_q      <= 1'b1;
              resp_val_q <= 1'b1;
            end
          end
        end
        default: state_q <= S_INIT;
      endcase
    end
  end

  assign core_req_rdy           = rdy_q;
  assign core_resp_val          = resp_val_q;
  assign core_resp_rdata        = rdata_q;
  assign core_irq               = irq_q;
  assign transducer_l15_val     = l15_val_q;
  assign transducer_l15_rqtype  = rqtype_q;
  assign transducer_l15_size    = size_q;
  assign transducer_l15_address = addr_q;
  assign transducer_l15_data    = data_q;
  assign transducer_l15_req_ack = l15_transducer_val;

endmodule

`default_nettype wire

// File: tb/tb_core_modport.sv
// ============================================================================
// tb_core_modport : scoreboard bench for core_modport
// Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_core_modport;

  logic        clk = 1'b0;
  logic        nrst;
  logic        core_req_val;
  logic        core_req_rdy;
  logic        core_req_we;
  logic [1:0]  core_req_size;
  logic [31:0] core_req_addr;
  logic [31:0] core_req_wdata;
  logic        core_resp_val;
  logic [31:0] core_resp_rdata;
  logic        core_irq;
  logic [4:0]  transducer_l15_rqtype;
  logic [2:0]  transducer_l15_size;
  logic [31:0] transducer_l15_address;
  logic [63:0] transducer_l15_data;
  logic        transducer_l15_val;
  logic        l15_transducer_ack;
  logic        l15_transducer_header_ack;
  logic        l15_transducer_val;
  logic [63:0] l15_transducer_data_0;
  logic [63:0] l15_transducer_data_1;
  logic [31:0] l15_transducer_returntype;
  logic        transducer_l15_req_ack;
  logic        external_interrupt;

  always #5 clk = ~clk;

  core_modport dut (
    .clk                       (clk),
    .nrst                      (nrst),
    .core_req_val              (core_req_val),
    .core_req_rdy              (core_req_rdy),
    .core_req_we               (core_req_we),
    .core_req_size             (core_req_size),
    .core_req_addr             (core_req_addr),
    .core_req_wdata            (core_req_wdata),
    .core_resp_val             (core_resp_val),
    .core_resp_rdata           (core_resp_rdata),
    .core_irq                  (core_irq),
    .transducer_l15_rqtype     (transducer_l15_rqtype),
    .transducer_l15_size       (transducer_l15_size),
    .transducer_l15_address    (transducer_l15_address),
    .transducer_l15_data       (transducer_l15_data),
    .transducer_l15_val        (transducer_l15_val),
    .l15_transducer_ack        (l15_transducer_ack),
    .l15_transducer_header_ack (l15_transducer_header_ack),
    .l15_transducer_val        (l15_transducer_val),
    .l15_transducer_data_0     (l15_transducer_data_0),
    .l15_transducer_data_1     (l15_transducer_data_1),
    .l15_transducer_returntype (l15_transducer_returntype),
    .transducer_l15_req_ack    (transducer_l15_req_ack),
    .external_interrupt        (external_interrupt)
  );

  typedef struct {
    logic        is_load;
    logic [31:0] rdata;
  } exp_t;

  typedef struct {
    logic        we;
    logic [1:0]  sz;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  esz;
    logic [63:0] edata;
    logic [63:0] d0;
    logic [31:0] erd;
    int          dly;
    logic        int_first;
  } req_t;

  exp_t sb_q[$];
  req_t tbl[8];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard side: every response pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!nrst && core_resp_val) begin
      if (sb_q.size() == 0) begin
        chk("resp_spurious", 64'd1, 64'd0);
      end else begin
        e = sb_q.pop_front();
        if (e.is_load) chk("resp_rdata", {32'd0, core_resp_rdata}, {32'd0, e.rdata});
      end
    end
  end

  task automatic wake_up();
    l15_transducer_val        = 1'b1;
    l15_transducer_returntype = 32'd7;
    #1;
    chk("req_ack_comb", {63'd0, transducer_l15_req_ack}, 64'd1);
    tick();
    l15_transducer_val = 1'b0;
    chk("rdy_after_wake", {63'd0, core_req_rdy}, 64'd1);
  endtask

  task automatic run_req(input req_t r);
    exp_t e;
    chk("rdy_idle", {63'd0, core_req_rdy}, 64'd1);
    core_req_val   = 1'b1;
    core_req_we    = r.we;
    core_req_size  = r.sz;
    core_req_addr  = r.addr;
    core_req_wdata = r.wdata;
    tick();
    core_req_val = 1'b0;
    chk("l15_val_up", {63'd0, transducer_l15_val}, 64'd1);
    chk("rdy_busy", {63'd0, core_req_rdy}, 64'd0);
    chk("rqtype", {59'd0, transducer_l15_rqtype}, r.we ? 64'd1 : 64'd0);
    chk("size", {61'd0, transducer_l15_size}, {61'd0, r.esz});
    chk("address", {32'd0, transducer_l15_address}, {32'd0, r.addr});
    if (r.we) chk("st_data", transducer_l15_data, r.edata);
    for (int i = 0; i < r.dly; i++) begin
      tick();
      chk("val_hold", {63'd0, transducer_l15_val}, 64'd1);
      chk("addr_hold", {32'd0, transducer_l15_address}, {32'd0, r.addr});
      chk("size_hold", {61'd0, transducer_l15_size}, {61'd0, r.esz});
    end
    l15_transducer_ack = 1'b1;
    tick();
    l15_transducer_ack = 1'b0;
    chk("val_drop", {63'd0, transducer_l15_val}, 64'd0);
    if (r.int_first) begin
      l15_transducer_val        = 1'b1;
      l15_transducer_returntype = 32'd7;
      tick();
      l15_transducer_val = 1'b0;
      chk("no_resp_on_int", {63'd0, core_resp_val}, 64'd0);
    end
    e.is_load = !r.we;
    e.rdata   = r.erd;
    sb_q.push_back(e);
    l15_transducer_val        = 1'b1;
    l15_transducer_returntype = r.we ? 32'd4 : 32'd0;
    l15_transducer_data_0     = r.d0;
    l15_transducer_data_1     = ~r.d0;
    tick();
    l15_transducer_val = 1'b0;
    chk("resp_val", {63'd0, core_resp_val}, 64'd1);
    tick();
    chk("resp_one_cycle", {63'd0, core_resp_val}, 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{1'b0, 2'd2, 32'h100, 32'h0,        3'b011, 64'h0,                64'h1122334455667788, 32'h11223344, 0, 1'b0};
    tbl[1] = '{1'b0, 2'd0, 32'h105, 32'h0,        3'b001, 64'h0,                64'h1122334455667788, 32'h00000066, 0, 1'b0};
    tbl[2] = '{1'b1, 2'd1, 32'h202, 32'h0000ABCD, 3'b010, 64'hABCDABCDABCDABCD, 64'h0,                32'h0,        0, 1'b0};
    tbl[3] = '{1'b0, 2'd1, 32'h306, 32'h0,        3'b010, 64'h0,                64'h1122334455667788, 32'h00007788, 3, 1'b1};
    tbl[4] = '{1'b1, 2'd0, 32'h401, 32'h123456A5, 3'b001, 64'hA5A5A5A5A5A5A5A5, 64'h0,                32'h0,        1, 1'b0};
    tbl[5] = '{1'b1, 2'd3, 32'h508, 32'hDEADBEEF, 3'b011, 64'hDEADBEEFDEADBEEF, 64'h0,                32'h0,        0, 1'b0};
    tbl[6] = '{1'b0, 2'd3, 32'h604, 32'h0,        3'b011, 64'h0,                64'h1122334455667788, 32'h55667788, 2, 1'b0};
    tbl[7] = '{1'b0, 2'd0, 32'h707, 32'h0,        3'b001, 64'h0,                64'h0123456789ABCDEF, 32'h000000EF, 0, 1'b0};

    nrst = 1'b1;
    core_req_val = 1'b0; core_req_we = 1'b0; core_req_size = 2'd0;
    core_req_addr = 32'd0; core_req_wdata = 32'd0;
    l15_transducer_ack = 1'b0; l15_transducer_header_ack = 1'b0;
    l15_transducer_val = 1'b0; l15_transducer_data_0 = 64'd0;
    l15_transducer_data_1 = 64'd0; l15_transducer_returntype = 32'd0;
    external_interrupt = 1'b1;
    tick();
    tick();
    chk("rst_rdy", {63'd0, core_req_rdy}, 64'd0);
    chk("rst_resp_val", {63'd0, core_resp_val}, 64'd0);
    chk("rst_rdata", {32'd0, core_resp_rdata}, 64'd0);
    chk("rst_irq", {63'd0, core_irq}, 64'd0);
    chk("rst_l15_val", {63'd0, transducer_l15_val}, 64'd0);
    chk("rst_rqtype", {59'd0, transducer_l15_rqtype}, 64'd0);
    chk("rst_size", {61'd0, transducer_l15_size}, 64'd0);
    chk("rst_addr", {32'd0, transducer_l15_address}, 64'd0);
    chk("rst_data", transducer_l15_data, 64'd0);
    nrst = 1'b0;
    external_interrupt = 1'b0;

    // Interrupt passthrough is one flop deep.
    tick();
    external_interrupt = 1'b1;
    #1;
    chk("irq_not_yet", {63'd0, core_irq}, 64'd0);
    tick();
    chk("irq_set", {63'd0, core_irq}, 64'd1);
    external_interrupt = 1'b0;
    tick();
    chk("irq_clr", {63'd0, core_irq}, 64'd0);

    // Blocked until wake-up; a non-interrupt return in INIT is ignored.
    core_req_val = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("init_rdy_low", {63'd0, core_req_rdy}, 64'd0);
      chk("init_no_req", {63'd0, transducer_l15_val}, 64'd0);
    end
    l15_transducer_val        = 1'b1;
    l15_transducer_returntype = 32'd0;
    tick();
    l15_transducer_val = 1'b0;
    tick();
    chk("init_ignore_ret", {63'd0, core_req_rdy}, 64'd0);
    core_req_val = 1'b0;
    wake_up();

    for (int i = 0; i < 8; i++) run_req(tbl[i]);

    // Reset while the request is still on the L1.5 channel.
    core_req_val  = 1'b1;
    core_req_we   = 1'b0;
    core_req_size = 2'd2;
    core_req_addr = 32'h800;
    tick();
    core_req_val = 1'b0;
    chk("pre_rst_val", {63'd0, transducer_l15_val}, 64'd1);
    nrst = 1'b1;
    #1;
    chk("rst_req_val", {63'd0, transducer_l15_val}, 64'd0);
    chk("rst_req_rdy", {63'd0, core_req_rdy}, 64'd0);
    chk("rst_req_addr", {32'd0, transducer_l15_address}, 64'd0);
    tick();
    nrst = 1'b0;
    wake_up();

    // Reset while waiting for the return.
    core_req_val  = 1'b1;
    core_req_addr = 32'h900;
    tick();
    core_req_val       = 1'b0;
    l15_transducer_ack = 1'b1;
    tick();
    l15_transducer_ack = 1'b0;
    nrst = 1'b1;
    #1;
    chk("rst_resp_l15_val", {63'd0, transducer_l15_val}, 64'd0);
    chk("rst_resp_rdy", {63'd0, core_req_rdy}, 64'd0);
    chk("rst_resp_rqtype", {59'd0, transducer_l15_rqtype}, 64'd0);
    tick();
    nrst = 1'b0;
    core_req_val = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rst_no_req", {63'd0, transducer_l15_val}, 64'd0);
    end
    core_req_val = 1'b0;
    wake_up();
    run_req(tbl[0]);

    tick();
    tick();
    chk("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/core_modport.md
# core_modport

Core-side memory port bridge between the in-order core's single outstanding load/store port and the OpenPiton L1.5 transducer interface (`l15_*` / `transducer_l15_*`). It serializes one request at a time and translates core opcode and size into OpenPiton request types and message sizes. It extracts load data from the 64-bit L1.5 return and forwards the external interrupt. After reset it stays blocked until the L1.5 delivers its wake-up return.

## Interface
Parameters:
- `LOAD_RQ`, 5'b00000: OpenPiton load request type.
- `STORE_RQ`, 5'b00001: OpenPiton store request type.
- `LOAD_RET`, 4'h0: load return type.
- `ST_ACK`, 4'h4: store acknowledge return type.
- `INT_RET`, 4'h7: interrupt/wake-up return type.

Ports:
- `clk` in 1: single clock, rising edge.
- `nrst` in 1: asynchronous, active-high reset; the name is kept for codebase consistency.
- `core_req_val` in 1: core request valid.
- `core_req_rdy` out 1: bridge accepts a request this cycle.
- `core_req_we` in 1: 1 = store, 0 = load.
- `core_req_size` in 2: 0 = byte, 1 = half, 2 = word; 3 is treated as word.
- `core_req_addr` in 32: byte address.
- `core_req_wdata` in 32: store data, right-aligned.
- `core_resp_val` out 1: one-cycle response pulse (load data or store done).
- `core_resp_rdata` out 32: load data, zero-extended.
- `core_irq` out 1: registered `external_interrupt`.
- `transducer_l15_rqtype` out 5, `transducer_l15_size` out 3, `transducer_l15_address` out 32, `transducer_l15_data` out 64, `transducer_l15_val` out 1: request channel.
- `l15_transducer_ack` in 1, `l15_transducer_header_ack` in 1: request accepted.
- `l15_transducer_val` in 1, `l15_transducer_data_0` in 64, `l15_transducer_data_1` in 64, `l15_transducer_returntype` in 32: return channel.
- `transducer_l15_req_ack` out 1: return consumed.
- `external_interrupt` in 1.

## Operation
- States: INIT, IDLE, REQ, RESP.
- INIT: entered on reset.
  - Waits for `l15_transducer_val` with `returntype[3:0]==INT_RET`, then goes to IDLE.
  - Any other return in INIT is acked and ignored.
- IDLE:
  - `core_req_rdy=1`.
  - On `core_req_val`, the request fields are registered and the state goes to REQ.
- REQ:
  - `transducer_l15_val=1`; all request fields are held stable.
  - On `l15_transducer_ack==1`, the state goes to RESP. `header_ack` is ignored for the handshake.
- RESP: waits for `l15_transducer_val`.
  - On `LOAD_RET` or `ST_ACK`, pulses `core_resp_val` and returns to IDLE.
  - `INT_RET` or other types are acked, produce no core response, and the state stays in RESP.
- Request encoding:
  - `rqtype = we ? STORE_RQ : LOAD_RQ`.
  - `size`: byte → 3'b001, half → 3'b010, word → 3'b011.
  - `address = core_req_addr`, unmodified. The bridge performs no alignment check.
- Store data is replicated across 64 bits:
  - byte: 8× `wdata[7:0]`;
  - half: 4× `wdata[15:0]`;
  - word: 2× `wdata[31:0]`.
- Load data is extracted from `data_0` using big-endian lane order, with offset `o = addr[2:0]` of the outstanding request:
  - byte: `data_0[63-8o -: 8]`;
  - half: `data_0[63-8o -: 16]`;
  - word: `data_0[63-8o -: 32]`.
  - The result is zero-extended. `data_1` is unused.
- `transducer_l15_req_ack = l15_transducer_val`, combinational, in every state.
- `core_irq` is `external_interrupt` delayed one flop.

## Timing
- Reset values: state INIT, and all of the following are 0:
  - `core_req_rdy`, `core_resp_val`, `core_resp_rdata`, `core_irq`;
  - `transducer_l15_val`, `transducer_l15_rqtype`, `transducer_l15_size`, `transducer_l15_address`, `transducer_l15_data`.
- Core accept at edge N → `transducer_l15_val` high from N+1.
- Ack sampled at edge M → `transducer_l15_val` low from M+1.
- Return sampled at edge K → `core_resp_val`/`core_resp_rdata` valid for the single cycle after K.
  - `core_resp_rdata` holds its value until the next response.
- Minimum load latency, core accept to response, is 3 cycles when ack and return are immediate.
- `core_req_rdy` is 0 in INIT, REQ and RESP, so there is only one outstanding request.
- A return arriving in the same cycle as the ack in REQ is ignored. The L1.5 guarantees the return arrives at least one cycle after the ack.
- Reset asserted mid-transaction aborts the transaction: outputs return to reset values immediately, and the state goes to INIT, which waits again for `INT_RET`.

## Test plan
- Wake-up gating:
  - Reset, then drive `core_req_val=1`: `core_req_rdy` stays 0.
  - Drive `l15_transducer_val=1`, `returntype=7`: `core_req_rdy=1` the next cycle.
- Word load:
  - Request `addr=0x100`, word.
  - Expect `rqtype=0`, `size=3'b011`, `address=0x100`, `val` high for 1 cycle with immediate ack.
  - Return `LOAD_RET` with `data_0=0x11223344_55667788`: `core_resp_rdata=0x11223344`.
- Byte load:
  - Request `addr=0x105`, byte.
  - Return the same `data_0`: `core_resp_rdata=0x00000066`.
- Half store:
  - Request `addr=0x202`, `wdata=0xABCD`.
  - Expect `rqtype=1`, `size=3'b010`, `data=0xABCDABCD_ABCDABCD`.
  - `ST_ACK` → one `core_resp_val` pulse.
- Delayed ack:
  - Hold `l15_transducer_ack=0` for 3 cycles: `transducer_l15_val` and all request fields stay stable.
  - Release ack: `val` drops next cycle.
- Reset mid-request:
  - Assert `nrst` while in RESP: `transducer_l15_val=0` and `core_req_rdy=0` immediately.
  - After release, no request is issued until `INT_RET`.
